// File: rtl/probe_word_source.sv
// probe_word_source: serializes captured PROBE values as {header, NW data words} packets on the DATAUP/DATAVALID/ACK/DELAY link; UCLK/URST clock and sync reset, CAPTURE/CHANGE_EN capture triggers, OVERRUN/DROPS report captures dropped while the pending slot is full
module probe_word_source #(
  parameter int WIDTH = 64,
  parameter logic [15:0] PROBE_ID = 16'h0000
) (
  input  logic             UCLK,
  input  logic             URST,
  input  logic [WIDTH-1:0] PROBE,
  input  logic             CAPTURE,
  input  logic             CHANGE_EN,
  output logic [31:0]      DATAUP,
  output logic             DATAVALID,
  output logic             DELAY,
  input  logic             ACK,
  output logic             OVERRUN,
  output logic [7:0]       DROPS
);
  localparam int NW = (WIDTH + 31) / 32;
  localparam int SW = NW * 32;
  localparam logic [7:0] NW8 = 8'(NW);
  localparam logic [7:0] LAST = 8'(NW - 1);
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
  state_t state;
  logic [SW-1:0] shadow;
  logic [WIDTH-1:0] pending, last;
  logic pend_v;
  logic [7:0] seq, idx;
  logic cap, lw;
  function automatic logic [31:0] word_at(input logic [SW-1:0] s, input logic [7:0] i);
    logic [SW-1:0] t;
    t = s >> {i, 5'b0};
    return t[31:0];
  endfunction
  assign cap = CAPTURE || (CHANGE_EN && PROBE != last);
  assign lw = state == DATA && ACK && idx == LAST;
  assign DATAVALID = state != IDLE;
  assign DELAY = DATAVALID || pend_v;
  always_ff @(posedge UCLK) begin
    if (URST) begin
      state <= IDLE;
      shadow <= '0;
      pending <= '0;
      last <= '0;
      pend_v <= 1'b0;
      seq <= '0;
      idx <= '0;
      DATAUP <= '0;
      OVERRUN <= 1'b0;
      DROPS <= '0;
    end else begin
      if (cap) last <= PROBE;
      if (cap && state != IDLE && !lw) begin
        if (!pend_v) begin
          pending <= PROBE;
          pend_v <= 1'b1;
        end else begin
          OVERRUN <= 1'b1;
          DROPS <= DROPS + {7'd0, DROPS != 8'hff};
        end
      end
      case (state)
        IDLE: if (cap) begin
          shadow <= SW'(PROBE);
          DATAUP <= {PROBE_ID, NW8, seq};
          state <= HDR;
        end
        HDR: if (ACK) begin
          seq <= seq + 8'd1;
          idx <= '0;
          DATAUP <= word_at(shadow, 8'd0);
          state <= DATA;
        end
        DATA: if (ACK) begin
          if (idx != LAST) begin
            idx <= idx + 8'd1;
            DATAUP <= word_at(shadow, idx + 8'd1);
          end else if (pend_v || cap) begin
            // a capture on this edge refills pending only if pending is being promoted now
            shadow <= pend_v ? SW'(pending) : SW'(PROBE);
            pend_v <= pend_v && cap;
            if (pend_v && cap) pending <= PROBE;
            DATAUP <= {PROBE_ID, NW8, seq};
            state <= HDR;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_probe_word_source.sv
// tb_probe_word_source: randomized scoreboard bench for probe_word_source against a packet-level reference model
module tb_probe_word_source;
  logic UCLK = 1'b0;
  logic URST = 1'b1;
  logic [63:0] PROBE = '0;
  logic CAPTURE = 1'b0, CHANGE_EN = 1'b0, ACK = 1'b0;
  logic [31:0] DATAUP;
  logic DATAVALID, DELAY, OVERRUN;
  logic [7:0] DROPS;
  logic [39:0] p40 = '0;
  logic cap40 = 1'b0;
  logic [31:0] dup40;
  logic dv40, dl40, ov40;
  logic [7:0] dr40;
  int n_chk = 0, n_fail = 0;
  logic [31:0] exp_q[$];
  bit mq[$];
  int m_npk = 0;
  logic [7:0] m_pseq = '0, m_drops = '0;
  logic [63:0] m_last = '0;
  logic m_ovr = 1'b0, m_valid = 1'b0, m_delay = 1'b0;
  probe_word_source #(.WIDTH(64), .PROBE_ID(16'hBEEF)) dut (
    .UCLK(UCLK), .URST(URST), .PROBE(PROBE), .CAPTURE(CAPTURE), .CHANGE_EN(CHANGE_EN),
    .DATAUP(DATAUP), .DATAVALID(DATAVALID), .DELAY(DELAY), .ACK(ACK),
    .OVERRUN(OVERRUN), .DROPS(DROPS)
  );
  probe_word_source #(.WIDTH(40), .PROBE_ID(16'h0040)) dut40 (
    .UCLK(UCLK), .URST(URST), .PROBE(p40), .CAPTURE(cap40), .CHANGE_EN(1'b0),
    .DATAUP(dup40), .DATAVALID(dv40), .DELAY(dl40), .ACK(1'b1),
    .OVERRUN(ov40), .DROPS(dr40)
  );
  always #5 UCLK = ~UCLK;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge UCLK);
      #1;
    end
  endtask
  // reference model: a packet is a header plus two data words; at most two packets may be outstanding
  always @(posedge UCLK) begin
    if (URST) begin
      exp_q.delete();
      mq.delete();
      m_npk = 0;
      m_pseq = '0;
      m_last = '0;
      m_ovr = 1'b0;
      m_drops = '0;
    end else begin
      bit acc, done, cap;
      cap = CAPTURE || (CHANGE_EN && PROBE != m_last);
      acc = ACK && mq.size() > 0;
      done = acc && mq[0];
      if (cap) begin
        m_last = PROBE;
        if (m_npk - int'(done) < 2) begin
          exp_q.push_back({16'hBEEF, 8'd2, m_pseq});
          exp_q.push_back(PROBE[31:0]);
          exp_q.push_back(PROBE[63:32]);
          mq.push_back(1'b0);
          mq.push_back(1'b0);
          mq.push_back(1'b1);
          m_pseq = m_pseq + 8'd1;
          m_npk++;
        end else begin
          m_ovr = 1'b1;
          if (m_drops != 8'hff) m_drops = m_drops + 8'd1;
        end
      end
      if (acc) begin
        void'(mq.pop_front());
        if (done) m_npk--;
      end
    end
    m_valid = mq.size() > 0;
    m_delay = m_npk > 0;
  end
  always @(negedge UCLK) begin
    check("valid", {63'd0, DATAVALID}, {63'd0, m_valid});
    check("delay", {63'd0, DELAY}, {63'd0, m_delay});
    check("overrun", {63'd0, OVERRUN}, {63'd0, m_ovr});
    check("drops", {56'd0, DROPS}, {56'd0, m_drops});
    if (DATAVALID && m_valid) begin
      if (exp_q.size() == 0) check("word_missing", {32'd0, DATAUP}, 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        check("word", {32'd0, DATAUP}, {32'd0, exp_q[0]});
        if (ACK && !URST) void'(exp_q.pop_front());
      end
    end
  end
  initial begin
    step(3);
    URST = 1'b0;
    @(negedge UCLK);
    check("reset_dataup", {32'd0, DATAUP}, 64'd0);
    check("reset_dv40", {63'd0, dv40}, 64'd0);
    step(1);
    // basic packet with ACK held high
    ACK = 1'b1;
    PROBE = 64'h1122334455667788;
    CAPTURE = 1'b1;
    step(1);
    CAPTURE = 1'b0;
    @(negedge UCLK) check("t1_hdr", {32'd0, DATAUP}, 64'hBEEF0200);
    @(negedge UCLK) check("t1_d0", {32'd0, DATAUP}, 64'h55667788);
    @(negedge UCLK) check("t1_d1", {32'd0, DATAUP}, 64'h11223344);
    @(negedge UCLK) check("t1_idle", {62'd0, DATAVALID, DELAY}, 64'd0);
    step(2);
    // header held under back-pressure
    ACK = 1'b0;
    CAPTURE = 1'b1;
    step(1);
    CAPTURE = 1'b0;
    step(5);
    check("t2_hold", {32'd0, DATAUP}, 64'hBEEF0201);
    ACK = 1'b1;
    step(5);
    // pending fills, third capture dropped
    ACK = 1'b0;
    PROBE = 64'hAAAA_0000_AAAA_0001;
    CAPTURE = 1'b1;
    step(1);
    CAPTURE = 1'b0;
    step(1);
    PROBE = 64'hBBBB_0000_BBBB_0002;
    CAPTURE = 1'b1;
    step(1);
    CAPTURE = 1'b0;
    step(1);
    PROBE = 64'hCCCC_0000_CCCC_0003;
    CAPTURE = 1'b1;
    step(1);
    CAPTURE = 1'b0;
    check("t3_drop", {55'd0, OVERRUN, DROPS}, {55'd0, 1'b1, 8'd1});
    ACK = 1'b1;
    step(10);
    // seq wrap, captures land on last-word-accept edges
    for (int i = 0; i < 300; i++) begin
      PROBE = {$urandom, $urandom};
      CAPTURE = 1'b1;
      step(1);
      CAPTURE = 1'b0;
      step(2);
    end
    step(5);
    // 40-bit instance: zero-filled upper word
    p40 = 40'hAB_CDEF0123;
    cap40 = 1'b1;
    step(1);
    cap40 = 1'b0;
    @(negedge UCLK) check("w40_hdr", {32'd0, dup40}, 64'h00400200);
    @(negedge UCLK) check("w40_d0", {32'd0, dup40}, 64'hCDEF0123);
    @(negedge UCLK) check("w40_d1", {32'd0, dup40}, 64'h000000AB);
    @(negedge UCLK) check("w40_idle", {63'd0, dv40}, 64'd0);
    step(1);
    // random traffic, enough drops to saturate DROPS
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 3) == 0) PROBE = {$urandom, $urandom};
      CAPTURE = $urandom_range(0, 3) == 0;
      CHANGE_EN = $urandom_range(0, 1) == 1;
      ACK = $urandom_range(0, 9) < 3;
      step(1);
    end
    CAPTURE = 1'b0;
    CHANGE_EN = 1'b0;
    ACK = 1'b1;
    step(10);
    check("sat_drops", {56'd0, DROPS}, 64'd255);
    // reset in the second data word with a pending entry
    PROBE = 64'h0101_0101_0202_0202;
    CAPTURE = 1'b1;
    step(1);
    PROBE = 64'h0303_0303_0404_0404;
    step(1);
    CAPTURE = 1'b0;
    step(1);
    check("rst_mid_d1", {32'd0, DATAUP}, 64'h01010101);
    URST = 1'b1;
    step(1);
    URST = 1'b0;
    @(negedge UCLK) check("rst_mid_state", {53'd0, DATAVALID, DELAY, OVERRUN, DROPS}, 64'd0);
    step(1);
    PROBE = 64'h0505_0505_0606_0606;
    CAPTURE = 1'b1;
    step(1);
    CAPTURE = 1'b0;
    @(negedge UCLK) check("rst_seq0", {32'd0, DATAUP}, 64'hBEEF0200);
    step(10);
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
